// File: rtl/mu_ram_arb_pkg.sv
// Shared types for the 1RW RAM arbiter: FSM encoding and port indices.
// No logic; zero latency.
// No flow control of its own.
package mu_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam int unsigned PORT0 = 0;
    localparam int unsigned PORT1 = 1;

    // One-hot grant vector for a port index.
    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mu_ram_1rw_arb_rr2.sv
// Two-way round-robin grant: masked requests, tie goes to the port that did not win last.
// Purely combinational, zero latency.
// No backpressure; an ungranted requester simply holds its request.
module mu_rr_arb2
    import mu_ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    logic [1:0] req_m;

    assign req_m = req & mask;

    always_comb begin
        gnt = 2'b00;
        case (req_m)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = port_onehot(~last_gnt);
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mu_ram_1rw_arb.sv
// Shares one 1RW RAM between two requesters with round-robin arbitration and locked bursts.
// Grant/steering combinational; read data returns one cycle after acceptance (RAM latency).
// Stalls a requester by withholding gnt; optional counters under MU_RAM_ARB_STATS_EN.
module mu_ram_1rw_arb
    import mu_ram_arb_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 12,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p0_lock,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    input  logic          p1_lock,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

`ifdef MU_RAM_ARB_STATS_EN
    input  logic          stats_clr,
    output logic [CW-1:0] p0_acc_cnt,
    output logic [CW-1:0] p1_acc_cnt,
    output logic [CW-1:0] p0_stall_cnt,
    output logic [CW-1:0] p1_stall_cnt,
`endif

    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wr,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rd
);

    if (CW < 1) begin : g_cw_chk
        $error("mu_ram_1rw_arb: CW must be at least 1");
    end

    arb_state_t state, state_nxt;
    logic [1:0] req, mask, gnt, acc;
    logic       last_gnt;
    logic       sel, sel_we, sel_lock, any_acc;
    logic       rd_pend, rd_owner;

    assign req = {p1_req, p0_req};

    mu_rr_arb2 u_rr (
        .req      (req),
        .mask     (mask),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    assign p0_gnt  = gnt[PORT0];
    assign p1_gnt  = gnt[PORT1];
    assign acc     = req & gnt;
    assign any_acc = |acc;

    // Port 0 is the default steering source so idle cycles present stable port-0 values.
    assign sel      = gnt[PORT1];
    assign sel_we   = sel ? p1_we   : p0_we;
    assign sel_lock = sel ? p1_lock : p0_lock;

    assign ram_addr = sel ? p1_addr  : p0_addr;
    assign ram_wr   = sel ? p1_wdata : p0_wdata;
    assign ram_we   = any_acc & sel_we;
    assign ram_re   = any_acc & ~sel_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_acc && sel_lock) begin
                    state_nxt = sel ? LOCK1 : LOCK0;
                end
            end
            LOCK0: begin
                if (acc[PORT0] && !p0_lock) begin
                    state_nxt = IDLE;
                end
            end
            LOCK1: begin
                if (acc[PORT1] && !p1_lock) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The lock holder alone is eligible; a dropped request leaves the lock in place.
    always_comb begin
        mask = 2'b11;
        case (state)
            IDLE:    mask = 2'b11;
            LOCK0:   mask = 2'b01;
            LOCK1:   mask = 2'b10;
            default: mask = 2'b11;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend <= ram_re;
            if (any_acc) begin
                last_gnt <= sel;
            end
            if (ram_re) begin
                rd_owner <= sel;
            end
        end
    end

    assign p0_rvalid = rd_pend & ~rd_owner;
    assign p1_rvalid = rd_pend &  rd_owner;
    assign p0_rdata  = ram_rd;
    assign p1_rdata  = ram_rd;

`ifdef MU_RAM_ARB_STATS_EN
    logic [1:0] stall;

    assign stall = req & ~gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_acc_cnt   <= '0;
            p1_acc_cnt   <= '0;
            p0_stall_cnt <= '0;
            p1_stall_cnt <= '0;
        end else if (stats_clr) begin
            p0_acc_cnt   <= '0;
            p1_acc_cnt   <= '0;
            p0_stall_cnt <= '0;
            p1_stall_cnt <= '0;
        end else begin
            if (acc[PORT0] && (p0_acc_cnt != '1)) begin
                p0_acc_cnt <= p0_acc_cnt + 1'b1;
            end
            if (acc[PORT1] && (p1_acc_cnt != '1)) begin
                p1_acc_cnt <= p1_acc_cnt + 1'b1;
            end
            if (stall[PORT0] && (p0_stall_cnt != '1)) begin
                p0_stall_cnt <= p0_stall_cnt + 1'b1;
            end
            if (stall[PORT1] && (p1_stall_cnt != '1)) begin
                p1_stall_cnt <= p1_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mu_ram_1rw_arb.sv
// Directed bench for mu_ram_1rw_arb with a behavioural 1RW RAM (registered read).
// Memory is preloaded with addr[7:0]^8'h3C so read data is known without prior writes.
module tb_mu_ram_1rw_arb;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr, ram_rd;
    logic          ram_we, ram_re;
`ifdef MU_RAM_ARB_STATS_EN
    logic          stats_clr;
    logic [CW-1:0] p0_acc_cnt, p1_acc_cnt, p0_stall_cnt, p1_stall_cnt;
`endif

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int fails  = 0;

    mu_ram_1rw_arb #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_lock   (p0_lock),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_lock   (p1_lock),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
`ifdef MU_RAM_ARB_STATS_EN
        .stats_clr    (stats_clr),
        .p0_acc_cnt   (p0_acc_cnt),
        .p1_acc_cnt   (p1_acc_cnt),
        .p0_stall_cnt (p0_stall_cnt),
        .p1_stall_cnt (p1_stall_cnt),
`endif
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_rd    (ram_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wr;
        end else if (ram_re) begin
            ram_rd <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic lock);
        p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_lock = lock;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic lock);
        p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_lock = lock;
    endtask

    initial begin
        int cnt0, cnt1;
        logic exp_port;

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = DW'(i) ^ 8'h3C;
        end
        ram_rd = '0;
        rst_n  = 1'b0;
        drive0(1'b0, 1'b0, '0, '0, 1'b0);
        drive1(1'b0, 1'b0, '0, '0, 1'b0);
`ifdef MU_RAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        // Reset state
        #2;
        chk("rst_p0_rvalid", p0_rvalid, 1'b0);
        chk("rst_p1_rvalid", p1_rvalid, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_re", ram_re, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Tie from reset: port 0 first, then port 1
        drive0(1'b1, 1'b0, 12'h010, 8'h00, 1'b0);
        drive1(1'b1, 1'b0, 12'h020, 8'h00, 1'b0);
        #1;
        chk("tie_p0_gnt", p0_gnt, 1'b1);
        chk("tie_p1_gnt", p1_gnt, 1'b0);
        chk("tie_ram_re", ram_re, 1'b1);
        chk("tie_ram_addr", ram_addr, 12'h010);
        tick();
        p0_req = 1'b0;
        #1;
        chk("tie_p1_gnt_c1", p1_gnt, 1'b1);
        chk("tie_p0_rvalid_c1", p0_rvalid, 1'b1);
        chk("tie_p0_rdata_c1", p0_rdata, 8'h2C);
        chk("tie_p1_rvalid_c1", p1_rvalid, 1'b0);
        tick();
        p1_req = 1'b0;
        chk("tie_p1_rvalid_c2", p1_rvalid, 1'b1);
        chk("tie_p1_rdata_c2", p1_rdata, 8'h1C);
        chk("tie_p0_rvalid_c2", p0_rvalid, 1'b0);
        tick();
        chk("tie_p1_rvalid_c3", p1_rvalid, 1'b0);

        // Single write then read on port 0
        drive0(1'b1, 1'b1, 12'h010, 8'hA5, 1'b0);
        #1;
        chk("wr_p0_gnt", p0_gnt, 1'b1);
        chk("wr_ram_we", ram_we, 1'b1);
        chk("wr_ram_re", ram_re, 1'b0);
        chk("wr_ram_wr", ram_wr, 8'hA5);
        tick();
        p0_we = 1'b0;
        #1;
        chk("rd_p0_gnt", p0_gnt, 1'b1);
        chk("rd_ram_re", ram_re, 1'b1);
        chk("wr_no_rvalid", p0_rvalid, 1'b0);
        tick();
        p0_req = 1'b0;
        chk("rd_p0_rvalid", p0_rvalid, 1'b1);
        chk("rd_p0_rdata", p0_rdata, 8'hA5);
        chk("rd_p1_rvalid", p1_rvalid, 1'b0);
        tick();

        // Continuous contention: last grant was port 0, so port 1 leads
        drive0(1'b1, 1'b0, 12'h010, 8'h00, 1'b0);
        drive1(1'b1, 1'b0, 12'h020, 8'h00, 1'b0);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            exp_port = (i % 2 == 0);
            #1;
            chk($sformatf("cont_p0_gnt_%0d", i), p0_gnt, !exp_port);
            chk($sformatf("cont_p1_gnt_%0d", i), p1_gnt, exp_port);
            if (i > 0) begin
                chk($sformatf("cont_p0_rvalid_%0d", i), p0_rvalid, exp_port);
                chk($sformatf("cont_p1_rvalid_%0d", i), p1_rvalid, !exp_port);
                chk($sformatf("cont_rdata_%0d", i), p0_rdata, exp_port ? 8'hA5 : 8'h1C);
            end
            if (p0_gnt) cnt0++;
            if (p1_gnt) cnt1++;
            tick();
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        chk("cont_last_p0_rvalid", p0_rvalid, 1'b1);
        chk("cont_last_rdata", p0_rdata, 8'hA5);
        chk("cont_cnt0", cnt0, 4);
        chk("cont_cnt1", cnt1, 4);
        tick();

        // Locked burst on port 1 while port 0 keeps requesting
        drive0(1'b1, 1'b0, 12'h050, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive1(1'b1, 1'b1, 12'h100 + 12'(k), 8'h11 * 8'(k + 1), k < 3);
            #1;
            chk($sformatf("burst_p1_gnt_%0d", k), p1_gnt, 1'b1);
            chk($sformatf("burst_p0_gnt_%0d", k), p0_gnt, 1'b0);
            tick();
        end
        p1_req = 1'b0;
        #1;
        chk("burst_p0_gnt_after", p0_gnt, 1'b1);
        tick();
        p0_req = 1'b0;
        chk("burst_p0_rvalid", p0_rvalid, 1'b1);
        chk("burst_p0_rdata", p0_rdata, 8'h6C);
        chk("burst_mem_100", mem[12'h100], 8'h11);
        chk("burst_mem_101", mem[12'h101], 8'h22);
        chk("burst_mem_102", mem[12'h102], 8'h33);
        chk("burst_mem_103", mem[12'h103], 8'h44);
        drive1(1'b1, 1'b0, 12'h102, 8'h00, 1'b0);
        tick();
        p1_req = 1'b0;
        chk("burst_rb_rvalid", p1_rvalid, 1'b1);
        chk("burst_rb_rdata", p1_rdata, 8'h33);
        tick();

        // Lock holder drops req: other port stays stalled until release
        drive0(1'b1, 1'b1, 12'h200, 8'h77, 1'b1);
        #1;
        chk("hold_p0_gnt", p0_gnt, 1'b1);
        tick();
        p0_req = 1'b0;
        drive1(1'b1, 1'b0, 12'h020, 8'h00, 1'b0);
        #1;
        chk("hold_p1_stall_a", p1_gnt, 1'b0);
        chk("hold_p0_nogrant", p0_gnt, 1'b0);
        tick();
        chk("hold_p1_stall_b", p1_gnt, 1'b0);
        drive0(1'b1, 1'b1, 12'h201, 8'h88, 1'b0);
        #1;
        chk("hold_release_p0", p0_gnt, 1'b1);
        chk("hold_release_p1", p1_gnt, 1'b0);
        tick();
        p0_req = 1'b0;
        #1;
        chk("hold_after_p1", p1_gnt, 1'b1);
        tick();
        p1_req = 1'b0;
        tick();

        // Async reset during a locked read on port 0
        drive0(1'b1, 1'b0, 12'h200, 8'h00, 1'b1);
        tick();
        p0_req = 1'b0;
        chk("arst_pre_rvalid", p0_rvalid, 1'b1);
        chk("arst_pre_rdata", p0_rdata, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid_drop", p0_rvalid, 1'b0);
        p0_req = 1'b1;
        p0_lock = 1'b0;
        tick();
        chk("arst_read_in_reset", p0_rvalid, 1'b0);
        p0_req = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("arst_after_rvalid", p0_rvalid, 1'b0);
        drive1(1'b1, 1'b0, 12'h020, 8'h00, 1'b0);
        #1;
        chk("arst_idle_p1_gnt", p1_gnt, 1'b1);
        drive0(1'b1, 1'b0, 12'h010, 8'h00, 1'b0);
        #1;
        chk("arst_tie_p0_gnt", p0_gnt, 1'b1);
        chk("arst_tie_p1_gnt", p1_gnt, 1'b0);
        tick();
        p0_req = 1'b0;
        chk("arst_tie_p0_rvalid", p0_rvalid, 1'b1);
        chk("arst_tie_p1_gnt_next", p1_gnt, 1'b1);
        tick();
        p1_req = 1'b0;
        chk("arst_tie_p1_rvalid", p1_rvalid, 1'b1);
        tick();

`ifdef MU_RAM_ARB_STATS_EN
        // Since reset: p0 1 access, p1 1 access and 1 stall cycle
        drive0(1'b1, 1'b1, 12'h300, 8'h5A, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        p0_req = 1'b0;
        chk("stats_p0_acc_sat", p0_acc_cnt, 4'hF);
        chk("stats_p1_acc", p1_acc_cnt, 4'h1);
        chk("stats_p1_stall", p1_stall_cnt, 4'h1);
        chk("stats_p0_stall", p0_stall_cnt, 4'h0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("stats_clr_p0_acc", p0_acc_cnt, 4'h0);
        chk("stats_clr_p1_stall", p1_stall_cnt, 4'h0);
        tick();
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
